arbiter_v2: RTL

ARBITER_V2 -- requirements
Module: arbiter_v2

---
 rtl/arbiter_pkg.sv | 16 +
 rtl/rr_priority_encoder.sv | 40 ++++
 rtl/arbiter_v2.sv | 134 +++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared FSM state type and default parameters for arbiter_v2
package arbiter_pkg;

  localparam int DefDeviceMaxNumber = 4;
  localparam int DefClockMaxTimout  = 12;
  localparam int DefAddrSetup       = 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetup   = 3'd1,
    StWait    = 3'd2,
    StStrobe  = 3'd3,
    StRelease = 3'd4
  } arbState_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - combinational round-robin pick starting after lastGrant
module rr_priority_encoder
  import arbiter_pkg::*;
#(
  parameter int DeviceMaxNumber = DefDeviceMaxNumber
) (
  input  logic [DeviceMaxNumber-1:0]         request,
  input  logic [$clog2(DeviceMaxNumber)-1:0] lastGrant,
  output logic [DeviceMaxNumber-1:0]         oneHot,
  output logic [$clog2(DeviceMaxNumber)-1:0] index,
  output logic                               valid
);

  localparam int IdxW = $clog2(DeviceMaxNumber);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  // lastGrant < N and offset <= N, so a single subtraction implements the wrap
  always_comb begin
    oneHot = '0;
    index  = '0;
    valid  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = 1; i <= DeviceMaxNumber; i++) begin
      sum = {1'b0, lastGrant} + (IdxW+1)'(i);
      if (sum >= (IdxW+1)'(DeviceMaxNumber)) begin
        sum = sum - (IdxW+1)'(DeviceMaxNumber);
      end
      cand = sum[IdxW-1:0];
      if (!valid && request[cand]) begin
        valid        = 1'b1;
        index        = cand;
        oneHot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_v2.sv
// rtl/arbiter_v2.sv - round-robin bus arbiter with address timeout; ARBITER_V2_ERRCNT_EN adds err_count
module arbiter_v2
  import arbiter_pkg::*;
#(
  parameter int DeviceMaxNumber = DefDeviceMaxNumber,
  parameter int ClockMaxTimout  = DefClockMaxTimout,
  parameter int AddrSetup       = DefAddrSetup
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic [DeviceMaxNumber-1:0]         barq,
  output logic [DeviceMaxNumber-1:0]         bagd,
  output logic [$clog2(DeviceMaxNumber)-1:0] grant_idx,
  output logic                               busy,
  output logic                               addressvalid,
  input  logic                               TargetReady,
  output logic                               DataStrobe,
  output logic                               Error
`ifdef ARBITER_V2_ERRCNT_EN
  ,
  output logic [15:0]                        err_count
`endif
);

  localparam int IdxW   = $clog2(DeviceMaxNumber);
  localparam int CntW   = $clog2(ClockMaxTimout + 1);
  localparam int SetupW = $clog2(AddrSetup + 1);

  arbState_t             state;
  logic [IdxW-1:0]       lastGrant;
  logic [CntW-1:0]       timeoutCnt;
  logic [SetupW-1:0]     setupCnt;
  logic [DeviceMaxNumber-1:0] pickOneHot;
  logic [IdxW-1:0]       pickIdx;
  logic                  pickValid;
  logic                  ownerReq;

  rr_priority_encoder #(.DeviceMaxNumber(DeviceMaxNumber)) uPick (
    .request   (barq),
    .lastGrant (lastGrant),
    .oneHot    (pickOneHot),
    .index     (pickIdx),
    .valid     (pickValid)
  );

  assign ownerReq = barq[grant_idx];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= StIdle;
      bagd         <= '0;
      grant_idx    <= '0;
      busy         <= 1'b0;
      addressvalid <= 1'b0;
      DataStrobe   <= 1'b0;
      Error        <= 1'b0;
      timeoutCnt   <= '0;
      setupCnt     <= '0;
      lastGrant    <= IdxW'(DeviceMaxNumber - 1);
    end else begin
      DataStrobe <= 1'b0;
      Error      <= 1'b0;
      case (state)
        StIdle: begin
          if (pickValid) begin
            state     <= StSetup;
            bagd      <= pickOneHot;
            grant_idx <= pickIdx;
            busy      <= 1'b1;
            setupCnt  <= '0;
          end
        end
        StSetup: begin
          if (!ownerReq) begin
            state <= StRelease;
            bagd  <= '0;
          end else if (setupCnt == SetupW'(AddrSetup - 1)) begin
            state        <= StWait;
            addressvalid <= 1'b1;
            timeoutCnt   <= '0;
          end else begin
            setupCnt <= setupCnt + 1'b1;
          end
        end
        StWait: begin
          // abort beats completion; a ready target beats a same-cycle timeout
          if (!ownerReq) begin
            state        <= StRelease;
            bagd         <= '0;
            addressvalid <= 1'b0;
          end else if (TargetReady) begin
            state        <= StStrobe;
            DataStrobe   <= 1'b1;
            addressvalid <= 1'b0;
          end else if (timeoutCnt == CntW'(ClockMaxTimout - 1)) begin
            state        <= StStrobe;
            DataStrobe   <= 1'b1;
            Error        <= 1'b1;
            addressvalid <= 1'b0;
          end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
          end
        end
        StStrobe: begin
          state <= StRelease;
          bagd  <= '0;
        end
        StRelease: begin
          state      <= StIdle;
          busy       <= 1'b0;
          lastGrant  <= grant_idx;
          timeoutCnt <= '0;
        end
        default: begin
          state        <= StIdle;
          bagd         <= '0;
          busy         <= 1'b0;
          addressvalid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARBITER_V2_ERRCNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_count <= '0;
    end else if (Error && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
